// File: rtl/util_axis_char_stream_arbiter.sv
// Round-robin arbiter sharing one char-to-string converter between several AXIS byte
// sources; a grant is held until the source completes a string (terminator or length cap).
module util_axis_char_stream_arbiter #(
    parameter int         num_requesters = 4,
    parameter int         string_length  = 21,
    parameter logic [7:0] term_char      = 8'h0A,
    localparam int        id_w           = (num_requesters > 1) ? $clog2(num_requesters) : 1,
    localparam int        cnt_w          = $clog2(string_length + 1)
) (
    input  logic                        aclk,
    input  logic                        arst,
    input  logic [num_requesters*8-1:0] s_axis_tdata,
    input  logic [num_requesters-1:0]   s_axis_tvalid,
    output logic [num_requesters-1:0]   s_axis_tready,
    output logic [7:0]                  m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [id_w-1:0]             m_axis_tuser
);

    typedef enum logic {
        IDLE,
        PASS
    } state_t;

    state_t           state;
    logic [id_w-1:0]  grant;
    logic [id_w-1:0]  last_grant;
    logic [cnt_w-1:0] char_cnt;

    logic             found;
    logic [id_w-1:0]  next_grant;
    int               scan_idx;
    logic             out_ready;
    logic             accept;
    logic [7:0]       in_byte;
    logic             in_last;

    // Scan starts just after the previous winner so every source gets a turn.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        found      = 1'b0;
        next_grant = last_grant;
        scan_idx   = 0;
        for (int k = 1; k <= num_requesters; k++) begin
            scan_idx = (int'(last_grant) + k) % num_requesters;
            if (!found && s_axis_tvalid[scan_idx]) begin
                found      = 1'b1;
                next_grant = id_w'(scan_idx);
            end
        end
    end

    // The output register can take a byte whenever it is empty or draining this cycle.
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign in_byte   = s_axis_tdata[int'(grant)*8 +: 8];
    assign accept    = (state == PASS) && s_axis_tvalid[grant] && out_ready;
    assign in_last   = (in_byte == term_char) || (char_cnt == cnt_w'(string_length - 1));

    always_comb begin
        s_axis_tready = '0;
        if (state == PASS) begin
            s_axis_tready[grant] = out_ready;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (arst) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= id_w'(num_requesters - 1);
            char_cnt      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else begin
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= in_byte;
                m_axis_tlast  <= in_last;
                m_axis_tuser  <= grant;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= next_grant;
                        state <= PASS;
                    end
                end
                PASS: begin
                    if (accept) begin
                        if (in_last) begin
                            last_grant <= grant;
                            char_cnt   <= '0;
                            state      <= IDLE;
                        end else begin
                            char_cnt <= char_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_util_axis_char_stream_arbiter.sv
// Self-checking bench: per-source byte queues feed the arbiter; a string-framing model
// predicts every output beat and the round-robin order of string starts.
module tb_util_axis_char_stream_arbiter;

    localparam int         N    = 4;
    localparam int         SL   = 21;
    localparam logic [7:0] TERM = 8'h0A;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic           aclk = 1'b0;
    logic           arst;
    logic [N*8-1:0] s_axis_tdata;
    logic [N-1:0]   s_axis_tvalid;
    logic [N-1:0]   s_axis_tready;
    logic [7:0]     m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           m_axis_tlast;
    logic [1:0]     m_axis_tuser;

    always #5 aclk = ~aclk;

    util_axis_char_stream_arbiter #(
        .num_requesters(N),
        .string_length (SL),
        .term_char     (TERM)
    ) dut (
        .aclk         (aclk),
        .arst         (arst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [7:0]  src_q   [N][$];
    beat_t       exp_q   [N][$];
    int          acc_cyc [N][$];
    int          mcnt    [N];
    int          acc_cnt [N];
    int          start_order [$];
    int          cyc = 0;
    bit          in_string = 0;
    int          cur_src = 0;
    bit          bp = 0;
    bit          rst_req = 1;
    int          hold_src = -1;
    int          hold_at = 0;
    int          hold_left = 0;
    int          first_sv = -1;
    int          first_mv = -1;
    int          beat_cnt = 0;
    int          last_cnt = 0;
    int          ready_bad = 0;
    logic [11:0] prev_out = '0;
    bit          prev_stall = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Framing rule: a string ends on the terminator or on its SL-th character.
    task automatic send(input int src, input logic [7:0] b);
        beat_t e;
        src_q[src].push_back(b);
        e.data = b;
        e.last = (b == TERM) || (mcnt[src] == SL - 1);
        exp_q[src].push_back(e);
        mcnt[src] = e.last ? 0 : mcnt[src] + 1;
    endtask

    function automatic bit all_empty();
        bit r = 1;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) r = 0;
        end
        return r;
    endfunction

    task automatic check_beat();
        int    id = int'(m_axis_tuser);
        beat_t e;
        check("beat_pending", 32'(exp_q[id].size() > 0), 1);
        if (exp_q[id].size() > 0) begin
            e = exp_q[id].pop_front();
            check("beat_data", m_axis_tdata, e.data);
            check("beat_last", m_axis_tlast, e.last);
        end
        if (in_string) check("no_interleave", id, cur_src);
        else start_order.push_back(id);
        in_string = !m_axis_tlast;
        cur_src   = id;
        beat_cnt++;
        if (m_axis_tlast) last_cnt++;
    endtask

    // One clock cycle: drive at the falling edge, observe 1 ns later, before the rising edge.
    task automatic tick();
        logic [11:0] cur;
        logic [7:0]  tmp;
        @(negedge aclk);
        arst          = rst_req;
        m_axis_tready = bp ? 1'($urandom % 2) : 1'b1;
        for (int i = 0; i < N; i++) begin
            bit held;
            held = (i == hold_src) && (acc_cnt[i] == hold_at) && (hold_left > 0);
            if (held) hold_left--;
            s_axis_tvalid[i]       = (src_q[i].size() > 0) && !held;
            s_axis_tdata[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
        #1;
        if (first_sv < 0 && |s_axis_tvalid) first_sv = cyc;
        if (first_mv < 0 && m_axis_tvalid) first_mv = cyc;
        if ($countones(s_axis_tready) > 1) ready_bad++;
        cur = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser};
        if (!arst) begin
            if (prev_stall) check("stall_stable", cur, prev_out);
            if (m_axis_tvalid && m_axis_tready) check_beat();
            for (int i = 0; i < N; i++) begin
                if (s_axis_tvalid[i] && s_axis_tready[i]) begin
                    tmp = src_q[i].pop_front();
                    acc_cyc[i].push_back(cyc);
                    acc_cnt[i]++;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
        end else begin
            prev_stall = 0;
        end
        prev_out = cur;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bit done = 0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = !m_axis_tvalid && all_empty();
        end
        check("drain_done", done, 1);
    endtask

    initial begin
        int so, b0, l0, base, a0, a2, h, n;
        arst          = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            mcnt[i]    = 0;
            acc_cnt[i] = 0;
        end

        // Reset state
        tick();
        tick();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_sready", s_axis_tready, 0);
        rst_req = 0;

        // Single source, terminated string
        first_sv = -1;
        first_mv = -1;
        b0 = beat_cnt;
        l0 = last_cnt;
        so = start_order.size();
        for (int b = 8'h41; b <= 8'h45; b++) send(0, 8'(b));
        send(0, TERM);
        drain(100);
        check("single_latency", first_mv - first_sv, 2);
        check("single_beats", beat_cnt - b0, 6);
        check("single_lasts", last_cnt - l0, 1);
        check("single_src", start_order[so], 0);

        // Length cap: two full-length strings, then a short terminated one
        base = acc_cyc[1].size();
        so   = start_order.size();
        for (int b = 8'h30; b <= 8'h5F; b++) send(1, 8'(b));
        send(1, TERM);
        drain(300);
        check("cap_strings", start_order.size() - so, 3);
        check("cap_throughput", acc_cyc[1][base+1] - acc_cyc[1][base], 1);
        check("cap_turnaround1", acc_cyc[1][base+21] - acc_cyc[1][base+20], 2);
        check("cap_turnaround2", acc_cyc[1][base+42] - acc_cyc[1][base+41], 2);

        // Fairness from a fresh reset: all sources continuously valid
        rst_req = 1;
        tick();
        rst_req = 0;
        so = start_order.size();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                send(i, 8'(8'h41 + i));
                send(i, 8'(8'h61 + r));
                send(i, TERM);
            end
        end
        drain(400);
        for (int k = 0; k < 3 * N; k++) check("fair_order", start_order[so+k], k % N);

        // Backpressure with random downstream ready, sources 2 and 3
        bp = 1;
        for (int k = 0; k < 40; k++) begin
            send(2, ($urandom % 6 == 0) ? TERM : 8'($urandom_range(32, 126)));
            send(3, ($urandom % 6 == 0) ? TERM : 8'($urandom_range(32, 126)));
        end
        send(2, TERM);
        send(3, TERM);
        drain(2000);
        bp = 0;

        // Terminator landing exactly on the last allowed position
        b0 = beat_cnt;
        l0 = last_cnt;
        for (int k = 0; k < SL - 1; k++) send(0, 8'(8'h20 + k));
        send(0, TERM);
        send(0, 8'h58);
        send(0, TERM);
        drain(200);
        check("boundary_beats", beat_cnt - b0, SL + 2);
        check("boundary_lasts", last_cnt - l0, 2);

        // Granted source stalls mid-string while source 0 waits
        so        = start_order.size();
        a0        = acc_cyc[0].size();
        h         = acc_cyc[1].size();
        hold_src  = 1;
        hold_at   = acc_cnt[1] + 3;
        hold_left = 10;
        for (int k = 0; k < 5; k++) send(1, 8'(8'h61 + k));
        send(1, TERM);
        send(0, 8'h71);
        send(0, 8'h72);
        send(0, TERM);
        drain(200);
        hold_src = -1;
        check("hold_order0", start_order[so], 1);
        check("hold_order1", start_order[so+1], 0);
        check("hold_gap", acc_cyc[1][h+3] - acc_cyc[1][h+2], 11);
        check("hold_grant_kept", 32'(acc_cyc[0][a0] > acc_cyc[1][h+5]), 1);

        // Reset in the middle of a string
        a2 = acc_cnt[2];
        for (int k = 0; k < 10; k++) send(2, 8'(8'h30 + k));
        n = 0;
        while (acc_cnt[2] - a2 < 5 && n < 50) begin
            tick();
            n++;
        end
        check("rst_mid_reach", acc_cnt[2] - a2, 5);
        rst_req = 1;
        tick();
        rst_req = 0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            mcnt[i] = 0;
        end
        in_string = 0;
        tick();
        check("rst_mid_tvalid", m_axis_tvalid, 0);
        check("rst_mid_tdata", m_axis_tdata, 0);
        check("rst_mid_tlast", m_axis_tlast, 0);
        check("rst_mid_tuser", m_axis_tuser, 0);
        check("rst_mid_sready", s_axis_tready, 0);
        so = start_order.size();
        send(3, 8'h33);
        send(3, TERM);
        send(0, 8'h30);
        send(0, TERM);
        drain(100);
        check("post_rst_first", start_order[so], 0);
        check("post_rst_second", start_order[so+1], 3);

        check("ready_onehot", ready_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
